// File: rtl/branch_pkg.sv
// Shared types and helpers for the branch predictor / redirect controller.
package branch_pkg;

  // EX-stage branch type encodings; anything else means "not a branch".
  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLT  = 3'b011,
    BR_BGE  = 3'b100,
    BR_JALR = 3'b101,
    BR_JAL  = 3'b110
  } br_type_e;

  // 2-bit saturating counter values.
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  typedef enum logic [0:0] {
    ST_IDLE,
    ST_FLUSH
  } state_e;

  // Conditional branches train the BHT; jumps do not.
  function automatic logic is_cond(logic [2:0] br_type);
    return (br_type >= BR_BEQ) && (br_type <= BR_BGE);
  endfunction

  function automatic logic is_jump(logic [2:0] br_type);
    return (br_type == BR_JALR) || (br_type == BR_JAL);
  endfunction

  function automatic logic [1:0] ctr_update(logic [1:0] ctr, logic taken);
    if (taken) return (ctr == ST) ? ST : ctr + 2'd1;
    else       return (ctr == SNT) ? SNT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/bht_2bit.sv
// Branch history table: 2**IDX_W two-bit saturating counters, one async read port and one
// synchronous update port. Reset puts every entry in weakly-not-taken.
module bht_2bit
  import branch_pkg::*;
#(
  parameter int unsigned IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_ctr,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  localparam int unsigned Entries = 2 ** IDX_W;

  logic [1:0] ctr_q [Entries];

  // Counter array: reinit on reset, otherwise saturating update of one entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < Entries; i++) ctr_q[i] <= WNT;
    end else if (upd_en) begin
      ctr_q[upd_idx] <= ctr_update(ctr_q[upd_idx], upd_taken);
    end
  end

  // Read returns the pre-update value when the same entry is written this cycle.
  assign rd_ctr = ctr_q[rd_idx];

endmodule

// File: rtl/branch_pred_ctrl.sv
// Front-end branch scheduler: BHT lookup at IF, resolution at EX, and a one-cycle
// redirect/flush sequence on mispredict. Define PERF_CNT_EN to build the branch and
// mispredict performance counters; otherwise those ports read 0.
module branch_pred_ctrl
  import branch_pkg::*;
#(
  parameter int unsigned PC_W  = 32,
  parameter int unsigned IDX_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [PC_W-1:0] if_pc,
  output logic            pred_taken,
  input  logic            ex_valid,
  input  logic [2:0]      ex_br_type,
  input  logic            ex_taken,
  input  logic            ex_pred_taken,
  input  logic [PC_W-1:0] ex_pc,
  input  logic [PC_W-1:0] ex_target,
  output logic            redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            flush_if_id,
  output logic            flush_id_ex,
  output logic [31:0]     cnt_branches,
  output logic [31:0]     cnt_mispred
);

  state_e          state_q;
  logic [1:0]      rd_ctr;
  logic            cond;
  logic            resolve;
  logic            actual;
  logic            mispred;
  logic [PC_W-1:0] fix_pc;

  // Only the index bits of the fetch PC feed the table.
  logic unused_if_pc;
  assign unused_if_pc = ^{if_pc[PC_W-1:IDX_W+2], if_pc[1:0]};

  bht_2bit #(
    .IDX_W(IDX_W)
  ) u_bht (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (if_pc[IDX_W+1:2]),
    .rd_ctr   (rd_ctr),
    .upd_en   (resolve & cond),
    .upd_idx  (ex_pc[IDX_W+1:2]),
    .upd_taken(ex_taken)
  );

  assign pred_taken = if_valid & rd_ctr[1];

  // Resolve the EX instruction; anything in EX during FLUSH is wrong-path and ignored.
  always_comb begin
    cond    = is_cond(ex_br_type);
    resolve = (state_q == ST_IDLE) && ex_valid && (cond || is_jump(ex_br_type));
    actual  = cond ? ex_taken : 1'b1;
    mispred = resolve && (actual != ex_pred_taken);
    fix_pc  = actual ? ex_target : ex_pc + PC_W'(4);
  end

  // Redirect FSM with registered outputs; redirect_pc holds its last value when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      redirect    <= 1'b0;
      flush_if_id <= 1'b0;
      flush_id_ex <= 1'b0;
      redirect_pc <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (mispred) begin
            state_q     <= ST_FLUSH;
            redirect    <= 1'b1;
            flush_if_id <= 1'b1;
            flush_id_ex <= 1'b1;
            redirect_pc <= fix_pc;
          end
        end
        ST_FLUSH: begin
          state_q     <= ST_IDLE;
          redirect    <= 1'b0;
          flush_if_id <= 1'b0;
          flush_id_ex <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  logic [31:0] cnt_branches_q;
  logic [31:0] cnt_mispred_q;

  // Performance counters; free-running and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_branches_q <= '0;
      cnt_mispred_q  <= '0;
    end else begin
      if (resolve) cnt_branches_q <= cnt_branches_q + 32'd1;
      if (mispred) cnt_mispred_q  <= cnt_mispred_q + 32'd1;
    end
  end

  assign cnt_branches = cnt_branches_q;
  assign cnt_mispred  = cnt_mispred_q;
`else
  assign cnt_branches = '0;
  assign cnt_mispred  = '0;
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl: table of single-cycle transactions plus
// hand-written multi-cycle sequences (branch in EX during FLUSH, reset during FLUSH).
module tb_branch_pred_ctrl;
  import branch_pkg::*;

`ifdef PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic        ex_valid;
  logic [2:0]  ex_br_type;
  logic        ex_taken;
  logic        ex_pred_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_if_id;
  logic        flush_id_ex;
  logic [31:0] cnt_branches;
  logic [31:0] cnt_mispred;

  branch_pred_ctrl #(
    .PC_W (32),
    .IDX_W(4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_valid     (if_valid),
    .if_pc        (if_pc),
    .pred_taken   (pred_taken),
    .ex_valid     (ex_valid),
    .ex_br_type   (ex_br_type),
    .ex_taken     (ex_taken),
    .ex_pred_taken(ex_pred_taken),
    .ex_pc        (ex_pc),
    .ex_target    (ex_target),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .cnt_branches (cnt_branches),
    .cnt_mispred  (cnt_mispred)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        if_valid;
    logic [31:0] if_pc;
    logic        ex_valid;
    logic [2:0]  br;
    logic        tk;
    logic        pr;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        exp_pred;
    logic        exp_redir;
    logic [31:0] exp_rpc;
  } vec_t;

  typedef struct {
    logic        redir;
    logic [31:0] rpc;
  } exp_t;

  vec_t        tbl[$];
  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] last_rpc = '0;
  logic [31:0] exp_br = '0;
  logic [31:0] exp_mp = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [31:0] ipc, input logic ev,
                     input logic [2:0] br, input logic tk, input logic pr,
                     input logic [31:0] pc, input logic [31:0] tgt, input logic e_pred,
                     input logic e_redir, input logic [31:0] e_rpc);
    vec_t v;
    v.if_valid = iv; v.if_pc = ipc; v.ex_valid = ev; v.br = br; v.tk = tk; v.pr = pr;
    v.pc = pc; v.tgt = tgt; v.exp_pred = e_pred; v.exp_redir = e_redir; v.exp_rpc = e_rpc;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic [31:0] ipc, input logic ev,
                       input logic [2:0] br, input logic tk, input logic pr,
                       input logic [31:0] pc, input logic [31:0] tgt);
    if_valid = iv; if_pc = ipc; ex_valid = ev; ex_br_type = br;
    ex_taken = tk; ex_pred_taken = pr; ex_pc = pc; ex_target = tgt;
  endtask

  task automatic drive_idle();
    drive(1'b0, 32'h0, 1'b0, BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic chk_pred(input string nm, input logic exp);
    #1;
    chk({nm, " pred_taken"}, {31'd0, pred_taken}, {31'd0, exp});
  endtask

  // Push the expected registered outputs, clock once, then pop and compare.
  task automatic step(input string nm, input logic e_redir, input logic [31:0] e_rpc);
    exp_t e;
    e.redir = e_redir;
    e.rpc   = e_redir ? e_rpc : last_rpc;
    if (e_redir) last_rpc = e_rpc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    chk({nm, " redirect"},     {31'd0, redirect},    {31'd0, e.redir});
    chk({nm, " flush_if_id"},  {31'd0, flush_if_id}, {31'd0, e.redir});
    chk({nm, " flush_id_ex"},  {31'd0, flush_id_ex}, {31'd0, e.redir});
    chk({nm, " redirect_pc"},  redirect_pc,          e.rpc);
    chk({nm, " cnt_branches"}, cnt_branches,         PerfEn ? exp_br : 32'd0);
    chk({nm, " cnt_mispred"},  cnt_mispred,          PerfEn ? exp_mp : 32'd0);
  endtask

  task automatic count(input logic ev, input logic [2:0] br, input logic tk, input logic pr);
    logic act;
    if (ev && br >= 3'd1 && br <= 3'd6) begin
      act = (br >= 3'd5) ? 1'b1 : tk;
      exp_br++;
      if (act != pr) exp_mp++;
    end
  endtask

  initial begin
    // Expected BHT state noted per row (idx = pc[5:2], reset value 01).
    //   if_v   if_pc         ex_v  type     tk    pr    ex_pc         target        pred  redir rpc
    add(1'b1, 32'h100,      1'b1, BR_NONE, 1'b1, 1'b0, 32'h40,       32'h0,        1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h100,      1'b1, BR_BEQ,  1'b1, 1'b1, 32'h100,      32'h80,       1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h100,      1'b1, BR_BEQ,  1'b1, 1'b1, 32'h100,      32'h80,       1'b1, 1'b0, 32'h0);
    add(1'b1, 32'h100,      1'b1, 3'b111,  1'b1, 1'b0, 32'h100,      32'h80,       1'b1, 1'b0, 32'h0);
    add(1'b1, 32'h104,      1'b1, BR_BEQ,  1'b1, 1'b0, 32'h100,      32'h80,       1'b0, 1'b1, 32'h80);
    add(1'b1, 32'h100,      1'b1, BR_BNE,  1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234,    1'b1, 1'b1, 32'h0);
    add(1'b1, 32'hFFFF_FFFC, 1'b1, BR_JAL, 1'b0, 1'b0, 32'h200,      32'h400,      1'b0, 1'b1, 32'h400);
    add(1'b1, 32'h200,      1'b1, BR_JALR, 1'b0, 1'b1, 32'h300,      32'h500,      1'b1, 1'b0, 32'h0);
    add(1'b1, 32'h8,        1'b1, BR_BLT,  1'b0, 1'b0, 32'h8,        32'h10,       1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h8,        1'b1, BR_BGE,  1'b1, 1'b0, 32'h8,        32'h10,       1'b0, 1'b1, 32'h10);
    add(1'b0, 32'h100,      1'b0, BR_BEQ,  1'b1, 1'b0, 32'h8,        32'h99,       1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h8,        1'b1, 3'b111,  1'b1, 1'b0, 32'h8,        32'h99,       1'b0, 1'b0, 32'h0);
    add(1'b1, 32'h8,        1'b1, BR_BEQ,  1'b1, 1'b0, 32'h8,        32'hC,        1'b0, 1'b1, 32'hC);
    add(1'b1, 32'h8,        1'b1, BR_NONE, 1'b0, 1'b0, 32'h8,        32'h0,        1'b1, 1'b0, 32'h0);

    // Reset.
    rst = 1'b1;
    drive_idle();
    step("reset0", 1'b0, 32'h0);
    step("reset1", 1'b0, 32'h0);
    rst = 1'b0;
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].if_pc, 1'b0, BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
      chk_pred($sformatf("reset pc%08h", tbl[i].if_pc), 1'b0);
      if (i == 2) break;
    end

    // Table of single-cycle transactions; a mispredict row gets one idle FLUSH cycle.
    foreach (tbl[i]) begin
      drive(tbl[i].if_valid, tbl[i].if_pc, tbl[i].ex_valid, tbl[i].br, tbl[i].tk, tbl[i].pr,
            tbl[i].pc, tbl[i].tgt);
      chk_pred($sformatf("row%0d", i), tbl[i].exp_pred);
      count(tbl[i].ex_valid, tbl[i].br, tbl[i].tk, tbl[i].pr);
      step($sformatf("row%0d", i), tbl[i].exp_redir, tbl[i].exp_rpc);
      if (tbl[i].exp_redir) begin
        drive_idle();
        step($sformatf("row%0d flush-exit", i), 1'b0, 32'h0);
      end
    end

    // Valid BLT in EX during FLUSH is ignored. BHT: idx1=01, idx2=10 here.
    drive(1'b1, 32'h44, 1'b1, BR_BEQ, 1'b1, 1'b0, 32'h44, 32'h900);
    chk_pred("t5 pre", 1'b0);
    count(1'b1, BR_BEQ, 1'b1, 1'b0);
    step("t5 mispredict", 1'b1, 32'h900);
    drive(1'b1, 32'h48, 1'b1, BR_BLT, 1'b0, 1'b1, 32'h48, 32'h777);
    chk_pred("t5 flush", 1'b1);
    step("t5 blt in flush", 1'b0, 32'h0);
    drive(1'b1, 32'h48, 1'b0, BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_pred("t5 bht2 kept", 1'b1);
    drive(1'b1, 32'h44, 1'b0, BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_pred("t5 bht1 trained", 1'b1);
    step("t5 idle", 1'b0, 32'h0);

    // Reset during FLUSH. bht0 is 11 -> 10 on this not-taken update.
    drive(1'b1, 32'h100, 1'b1, BR_BEQ, 1'b0, 1'b1, 32'h100, 32'h0);
    chk_pred("t6 pre", 1'b1);
    count(1'b1, BR_BEQ, 1'b0, 1'b1);
    step("t6 mispredict", 1'b1, 32'h104);
    rst = 1'b1;
    drive_idle();
    exp_br = '0;
    exp_mp = '0;
    last_rpc = '0;
    step("t6 rst in flush", 1'b0, 32'h0);
    rst = 1'b0;
    drive(1'b1, 32'h100, 1'b0, BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_pred("t6 bht reinit", 1'b0);
    step("t6 post reset", 1'b0, 32'h0);

    // JAL predicted not-taken right after reset: counters read 1/1.
    drive(1'b1, 32'h10, 1'b1, BR_JAL, 1'b0, 1'b0, 32'h10, 32'h20);
    chk_pred("t6 jal", 1'b0);
    count(1'b1, BR_JAL, 1'b0, 1'b0);
    step("t6 jal", 1'b1, 32'h20);
    drive(1'b1, 32'h10, 1'b0, BR_NONE, 1'b0, 1'b0, 32'h0, 32'h0);
    chk_pred("t6 jal bht unchanged", 1'b0);
    step("t6 jal flush-exit", 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
